l1_cache_tag_stage: RTL and testbench
=====================================

Name: l1_cache_tag_stage

Overview:
- L1 cache tag lookup stage; sits directly upstream of cache_lru.
- Holds per-set, per-way tag and valid arrays. Runs a 2-cycle lookup pipeline: read, then compare.
- Drives cache_lru's access/update/fill ports and consumes fill_way_idx to place new lines.
- Hit/way results go downstream to the data-array stage.

Parameters:
- NUM_WAYS, 4, associativity (power of 2, ≥2)
- NUM_SETS, 64, sets per cache (power of 2)
- ADDR_WIDTH, 32, byte address width
- LINE_OFFSET_BITS, 6, log2 of line size in bytes
- ID_WIDTH, 4, opaque request tag carried through

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- lookup_en  in  1  lookup request
- lookup_addr  in  ADDR_WIDTH  lookup byte address
- lookup_id  in  ID_WIDTH  request tag
- fill_en  in  1  install line request
- fill_addr  in  ADDR_WIDTH  address of line to install
- invalidate_en  in  1  clear one way
- invalidate_set  in  SETS_LOG  set to clear
- invalidate_way  in  WAYS_LOG  way to clear
- lru_access_en  out  1  to cache_lru access_en
- lru_access_set  out  SETS_LOG  to cache_lru access_set
- lru_update_en  out  1  to cache_lru update_en
- lru_update_way_idx  out  WAYS_LOG  to cache_lru update_way_idx
- lru_fill_en  out  1  to cache_lru fill_en
- lru_fill_set  out  SETS_LOG  to cache_lru fill_set
- lru_fill_way_idx  in  WAYS_LOG  from cache_lru fill_way_idx
- result_valid  out  1  lookup result valid
- result_hit  out  1  tag match on a valid way
- result_way_idx  out  WAYS_LOG  matching way (0 on miss)
- result_addr  out  ADDR_WIDTH  echoed lookup_addr
- result_id  out  ID_WIDTH  echoed lookup_id
- fill_done_valid  out  1  line installed this cycle
- fill_done_way_idx  out  WAYS_LOG  way written
- fill_done_set  out  SETS_LOG  set written

Behaviour:
- Address split:
  - set = addr[LINE_OFFSET_BITS +: SETS_LOG]
  - tag = addr[ADDR_WIDTH-1 : LINE_OFFSET_BITS+SETS_LOG]
  - TAG_WIDTH is derived from these.
- Reset (async): all valid bits 0, tags 0, pipeline valid flags 0. Every output 0 except lru_*_set, which are combinational from address inputs.
- Stage 1, lookup cycle L:
  - lru_access_en = lookup_en; lru_access_set = set(lookup_addr), combinational.
  - Tag/valid row of the set is read and registered at the end of L, together with addr, id and s2_valid.
- Stage 2, cycle L+1:
  - Compare the registered tags against the registered tag, per way, gated by valid.
  - result_valid = s2_valid; result_hit = any match; result_way_idx = one-hot-to-index of the match.
  - lru_update_en = s2_valid & result_hit; lru_update_way_idx = result_way_idx.
  - This meets cache_lru's rule that update_en follows access_en by exactly one cycle.
  - Lookup throughput: 1 per cycle, no stall.
- Fill pipeline, fully pipelined (1 per cycle):
  - Cycle F: lru_fill_en = fill_en, lru_fill_set = set(fill_addr); fill_addr is registered.
  - Cycle F+1: sample lru_fill_way_idx. Drive fill_done_valid=1 with that way and the set. At the end of F+1, write tag and set valid=1.
- Write forwarding:
  - If a fill or invalidate write to set S occurs on the same edge that stage 1 captures set S, the captured row merges the written way's new tag/valid.
  - Result: a lookup issued in F+1 of a fill to the same line hits.
- Simultaneous fill write and invalidate to the same set/way on the same edge: fill wins (valid=1).
- Invalidate: clears valid[set][way] at the next edge; the tag is untouched.
- Multiple-way match: illegal (upstream never fills a resident line). A simulation assertion flags it; the lowest index is reported.
- Reset asserted mid-fill or mid-lookup: in-flight operations are dropped, no fill_done or result is produced, and all lines become invalid.

Decomposition:
- Shared package l1_cache_defs (defines.vh): L1_CACHE_NUM_WAYS/_LOG, L1_CACHE_NUM_SETS/_LOG, LINE_OFFSET_BITS, derived TAG_WIDTH, and set/tag extract macros.
- One natural sub-module: cache_tag_way. It holds one way's tag/valid array, the synchronous read with write-merge, and the comparator. It is instantiated NUM_WAYS times.
- The top level handles the pipeline registers, match encoding and the LRU interface.

Test Plan (cache_lru attached, NUM_SETS=64, set=addr[11:6]):
- After reset, lookup_en addr 0x0000_1040 id 3 → next cycle result_valid=1, hit=0, id=3, lru_update_en=0.
- Fill 0x0000_1040 at cycle 0 → cycle 1: fill_done_valid=1, set=1, way = LRU's fill_way_idx (0 from a fresh tree). Lookup at cycle 3 → cycle 4: hit=1, way=0, lru_update_en=1, update_way_idx=0.
- Four back-to-back fills to set 1 (tags 1..4) → fill_done ways 0,2,1,3. Four following lookups all hit with the matching ways.
- Fill 0x0000_2080 at cycle 0, lookup same address at cycle 1 → cycle 2 hit=1 (forwarding path).
- Invalidate set 1 way 2, then lookup the way-2 line → hit=0. Invalidate plus fill write to set 1 way 2 on the same edge → later lookup hits.
- Assert rst_n low in cycle F+1 of a fill → no fill_done; after release, a lookup of that address misses.

Source files
------------

// File: rtl/l1_cache_tag_stage_pkg.sv
// Shared geometry constants for the L1 tag stage and its way slices.
// Latency: n/a (constants only).
// Backpressure: n/a.
package l1_cache_tag_stage_pkg;

   localparam int L1_CACHE_NUM_WAYS        = 4;
   localparam int L1_CACHE_NUM_WAYS_LOG    = $clog2(L1_CACHE_NUM_WAYS);
   localparam int L1_CACHE_NUM_SETS        = 64;
   localparam int L1_CACHE_NUM_SETS_LOG    = $clog2(L1_CACHE_NUM_SETS);
   localparam int L1_CACHE_ADDR_WIDTH      = 32;
   localparam int L1_CACHE_LINE_OFFSET_BITS = 6;
   localparam int L1_CACHE_ID_WIDTH        = 4;
   // Everything above the set index is tag.
   localparam int L1_CACHE_TAG_WIDTH       = L1_CACHE_ADDR_WIDTH - L1_CACHE_LINE_OFFSET_BITS
                                             - L1_CACHE_NUM_SETS_LOG;

endpackage

// File: rtl/cache_tag_way.sv
// One way of the tag store: tag/valid arrays, registered row read with write merge, comparator.
// Latency: row read registered once; hit is combinational from the registered row.
// Backpressure: none; one read and one write/invalidate accepted every cycle.
module cache_tag_way #(
   parameter int NUM_SETS  = 64,
   parameter int TAG_WIDTH = 20,
   parameter int SETS_LOG  = $clog2(NUM_SETS)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [SETS_LOG-1:0]  rd_set,
   input  logic [TAG_WIDTH-1:0] cmp_tag,
   output logic                 hit,
   input  logic                 wr_en,
   input  logic [SETS_LOG-1:0]  wr_set,
   input  logic [TAG_WIDTH-1:0] wr_tag,
   input  logic                 inv_en,
   input  logic [SETS_LOG-1:0]  inv_set
);

   logic [TAG_WIDTH-1:0] tag_q [NUM_SETS];
   logic [TAG_WIDTH-1:0] tag_d [NUM_SETS];
   logic [NUM_SETS-1:0]  valid_q, valid_d;
   logic [TAG_WIDTH-1:0] rd_tag_q, rd_tag_d;
   logic                 rd_valid_q, rd_valid_d;

   // Next array state; the fill is applied after the invalidate so it wins on a collision.
   // The read row is taken from the next state, which forwards a same-edge write.
   always_comb begin
      tag_d   = tag_q;
      valid_d = valid_q;
      if (inv_en) begin
         valid_d[inv_set] = 1'b0;
      end
      if (wr_en) begin
         tag_d[wr_set]   = wr_tag;
         valid_d[wr_set] = 1'b1;
      end
      rd_tag_d   = tag_d[rd_set];
      rd_valid_d = valid_d[rd_set];
   end

   // Array and read-row registers; reset wipes every line.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < NUM_SETS; s++) begin
            tag_q[s] <= '0;
         end
         valid_q    <= '0;
         rd_tag_q   <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         tag_q      <= tag_d;
         valid_q    <= valid_d;
         rd_tag_q   <= rd_tag_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   assign hit = rd_valid_q && (rd_tag_q == cmp_tag);

endmodule

// File: rtl/l1_cache_tag_stage.sv
// L1 tag lookup stage: read/compare pipeline, fill install pipeline, cache_lru interface.
// Latency: lookup result 1 cycle after request; fill_done 1 cycle after fill_en.
// Backpressure: none; lookups and fills each accepted every cycle, no stall.
module l1_cache_tag_stage
   import l1_cache_tag_stage_pkg::*;
#(
   parameter int NUM_WAYS         = L1_CACHE_NUM_WAYS,
   parameter int NUM_SETS         = L1_CACHE_NUM_SETS,
   parameter int ADDR_WIDTH       = L1_CACHE_ADDR_WIDTH,
   parameter int LINE_OFFSET_BITS = L1_CACHE_LINE_OFFSET_BITS,
   parameter int ID_WIDTH         = L1_CACHE_ID_WIDTH,
   localparam int WAYS_LOG        = $clog2(NUM_WAYS),
   localparam int SETS_LOG        = $clog2(NUM_SETS)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  lookup_en,
   input  logic [ADDR_WIDTH-1:0] lookup_addr,
   input  logic [ID_WIDTH-1:0]   lookup_id,
   input  logic                  fill_en,
   input  logic [ADDR_WIDTH-1:0] fill_addr,
   input  logic                  invalidate_en,
   input  logic [SETS_LOG-1:0]   invalidate_set,
   input  logic [WAYS_LOG-1:0]   invalidate_way,
   output logic                  lru_access_en,
   output logic [SETS_LOG-1:0]   lru_access_set,
   output logic                  lru_update_en,
   output logic [WAYS_LOG-1:0]   lru_update_way_idx,
   output logic                  lru_fill_en,
   output logic [SETS_LOG-1:0]   lru_fill_set,
   input  logic [WAYS_LOG-1:0]   lru_fill_way_idx,
   output logic                  result_valid,
   output logic                  result_hit,
   output logic [WAYS_LOG-1:0]   result_way_idx,
   output logic [ADDR_WIDTH-1:0] result_addr,
   output logic [ID_WIDTH-1:0]   result_id,
   output logic                  fill_done_valid,
   output logic [WAYS_LOG-1:0]   fill_done_way_idx,
   output logic [SETS_LOG-1:0]   fill_done_set
);

   localparam int TAG_LSB   = LINE_OFFSET_BITS + SETS_LOG;
   localparam int TAG_WIDTH = ADDR_WIDTH - TAG_LSB;

   logic                  s2_valid_q, s2_valid_d;
   logic [ADDR_WIDTH-1:0] s2_addr_q, s2_addr_d;
   logic [ID_WIDTH-1:0]   s2_id_q, s2_id_d;
   logic                  f2_valid_q, f2_valid_d;
   logic [ADDR_WIDTH-1:0] f2_addr_q, f2_addr_d;

   logic [SETS_LOG-1:0]   lookup_set, f2_set;
   logic [TAG_WIDTH-1:0]  s2_tag, f2_tag;
   logic [NUM_WAYS-1:0]   way_hit;
   logic                  hit_any;
   logic [WAYS_LOG-1:0]   hit_idx;

   assign lookup_set = lookup_addr[LINE_OFFSET_BITS +: SETS_LOG];
   assign f2_set     = f2_addr_q[LINE_OFFSET_BITS +: SETS_LOG];
   assign s2_tag     = s2_addr_q[ADDR_WIDTH-1:TAG_LSB];
   assign f2_tag     = f2_addr_q[ADDR_WIDTH-1:TAG_LSB];

   // Next values of the lookup and fill pipeline registers.
   always_comb begin
      s2_valid_d = lookup_en;
      s2_addr_d  = lookup_addr;
      s2_id_d    = lookup_id;
      f2_valid_d = fill_en;
      f2_addr_d  = fill_addr;
   end

   // Pipeline registers; reset drops any in-flight lookup or fill.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid_q <= 1'b0;
         s2_addr_q  <= '0;
         s2_id_q    <= '0;
         f2_valid_q <= 1'b0;
         f2_addr_q  <= '0;
      end else begin
         s2_valid_q <= s2_valid_d;
         s2_addr_q  <= s2_addr_d;
         s2_id_q    <= s2_id_d;
         f2_valid_q <= f2_valid_d;
         f2_addr_q  <= f2_addr_d;
      end
   end

   // The fill writes the way the LRU picked, in the cycle after the fill request.
   for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
      cache_tag_way #(
         .NUM_SETS  (NUM_SETS),
         .TAG_WIDTH (TAG_WIDTH),
         .SETS_LOG  (SETS_LOG)
      ) u_way (
         .clk     (clk),
         .rst_n   (rst_n),
         .rd_set  (lookup_set),
         .cmp_tag (s2_tag),
         .hit     (way_hit[w]),
         .wr_en   (f2_valid_q && (lru_fill_way_idx == WAYS_LOG'(w))),
         .wr_set  (f2_set),
         .wr_tag  (f2_tag),
         .inv_en  (invalidate_en && (invalidate_way == WAYS_LOG'(w))),
         .inv_set (invalidate_set)
      );
   end

   // Encode the match vector; on an (illegal) multi-match the lowest way is reported.
   always_comb begin
      hit_any = 1'b0;
      hit_idx = '0;
      for (int w = NUM_WAYS - 1; w >= 0; w--) begin
         if (way_hit[w]) begin
            hit_any = 1'b1;
            hit_idx = WAYS_LOG'(w);
         end
      end
   end

   // Flag a line resident in more than one way of a set.
   always_ff @(posedge clk) begin
      if (rst_n && s2_valid_q) begin
         assert ($onehot0(way_hit))
            else $error("l1_cache_tag_stage: multiple ways hit for addr 0x%0h", s2_addr_q);
      end
   end

   assign lru_access_en      = lookup_en;
   assign lru_access_set     = lookup_set;
   assign result_valid       = s2_valid_q;
   assign result_hit         = s2_valid_q && hit_any;
   assign result_way_idx     = s2_valid_q ? hit_idx : '0;
   assign result_addr        = s2_addr_q;
   assign result_id          = s2_id_q;
   assign lru_update_en      = result_hit;
   assign lru_update_way_idx = result_way_idx;
   assign lru_fill_en        = fill_en;
   assign lru_fill_set       = fill_addr[LINE_OFFSET_BITS +: SETS_LOG];
   assign fill_done_valid    = f2_valid_q;
   assign fill_done_way_idx  = f2_valid_q ? lru_fill_way_idx : '0;
   assign fill_done_set      = f2_set;

endmodule

// File: tb/tb_l1_cache_tag_stage.sv
// Directed bench for l1_cache_tag_stage; the bench plays cache_lru by driving lru_fill_way_idx.
// Inputs change and outputs are sampled 1ns after the rising edge.
module tb_l1_cache_tag_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        lookup_en;
   logic [31:0] lookup_addr;
   logic [3:0]  lookup_id;
   logic        fill_en;
   logic [31:0] fill_addr;
   logic        invalidate_en;
   logic [5:0]  invalidate_set;
   logic [1:0]  invalidate_way;
   logic        lru_access_en;
   logic [5:0]  lru_access_set;
   logic        lru_update_en;
   logic [1:0]  lru_update_way_idx;
   logic        lru_fill_en;
   logic [5:0]  lru_fill_set;
   logic [1:0]  lru_fill_way_idx;
   logic        result_valid;
   logic        result_hit;
   logic [1:0]  result_way_idx;
   logic [31:0] result_addr;
   logic [3:0]  result_id;
   logic        fill_done_valid;
   logic [1:0]  fill_done_way_idx;
   logic [5:0]  fill_done_set;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   l1_cache_tag_stage dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .lookup_en          (lookup_en),
      .lookup_addr        (lookup_addr),
      .lookup_id          (lookup_id),
      .fill_en            (fill_en),
      .fill_addr          (fill_addr),
      .invalidate_en      (invalidate_en),
      .invalidate_set     (invalidate_set),
      .invalidate_way     (invalidate_way),
      .lru_access_en      (lru_access_en),
      .lru_access_set     (lru_access_set),
      .lru_update_en      (lru_update_en),
      .lru_update_way_idx (lru_update_way_idx),
      .lru_fill_en        (lru_fill_en),
      .lru_fill_set       (lru_fill_set),
      .lru_fill_way_idx   (lru_fill_way_idx),
      .result_valid       (result_valid),
      .result_hit         (result_hit),
      .result_way_idx     (result_way_idx),
      .result_addr        (result_addr),
      .result_id          (result_id),
      .fill_done_valid    (fill_done_valid),
      .fill_done_way_idx  (fill_done_way_idx),
      .fill_done_set      (fill_done_set)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      lookup_en     = 1'b0;
      fill_en       = 1'b0;
      invalidate_en = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   // Issue one lookup this cycle and check its result in the next.
   task automatic lookup_expect(input string name, input logic [31:0] addr, input logic [3:0] id,
                                input logic exp_hit, input logic [1:0] exp_way);
      lookup_en   = 1'b1;
      lookup_addr = addr;
      lookup_id   = id;
      tick();
      lookup_en = 1'b0;
      chk({name, ".valid"},   result_valid, 1);
      chk({name, ".hit"},     result_hit, exp_hit);
      chk({name, ".way"},     result_way_idx, exp_way);
      chk({name, ".id"},      result_id, id);
      chk({name, ".upd_en"},  lru_update_en, exp_hit);
      chk({name, ".upd_way"}, lru_update_way_idx, exp_way);
   endtask

   logic [31:0] fill_addrs [4] = '{32'h0000_1040, 32'h0000_2040, 32'h0000_3040, 32'h0000_4040};
   logic [1:0]  fill_ways  [4] = '{2'd0, 2'd2, 2'd1, 2'd3};

   initial begin
      rst_n            = 1'b0;
      lookup_en        = 1'b0;
      lookup_addr      = '0;
      lookup_id        = '0;
      fill_en          = 1'b0;
      fill_addr        = '0;
      invalidate_en    = 1'b0;
      invalidate_set   = '0;
      invalidate_way   = '0;
      lru_fill_way_idx = 2'd3;
      tick();
      tick();

      // Reset state: all registered outputs zero, fill way gated off.
      chk("rst.result_valid", result_valid, 0);
      chk("rst.result_hit",   result_hit, 0);
      chk("rst.result_addr",  result_addr, 0);
      chk("rst.upd_en",       lru_update_en, 0);
      chk("rst.fd_valid",     fill_done_valid, 0);
      chk("rst.fd_way",       fill_done_way_idx, 0);
      chk("rst.fd_set",       fill_done_set, 0);
      lru_fill_way_idx = 2'd0;
      rst_n = 1'b1;
      tick();

      // Cold lookup misses; access port is combinational.
      lookup_en   = 1'b1;
      lookup_addr = 32'h0000_1040;
      lookup_id   = 4'd3;
      #1;
      chk("cold.access_en",  lru_access_en, 1);
      chk("cold.access_set", lru_access_set, 1);
      tick();
      idle();
      chk("cold.valid",  result_valid, 1);
      chk("cold.hit",    result_hit, 0);
      chk("cold.way",    result_way_idx, 0);
      chk("cold.id",     result_id, 3);
      chk("cold.addr",   result_addr, 32'h0000_1040);
      chk("cold.upd_en", lru_update_en, 0);

      // Single fill, then a later lookup hits.
      fill_en   = 1'b1;
      fill_addr = 32'h0000_1040;
      #1;
      chk("fill.lru_fill_en",  lru_fill_en, 1);
      chk("fill.lru_fill_set", lru_fill_set, 1);
      tick();
      idle();
      lru_fill_way_idx = 2'd0;
      #1;
      chk("fill.fd_valid", fill_done_valid, 1);
      chk("fill.fd_set",   fill_done_set, 1);
      chk("fill.fd_way",   fill_done_way_idx, 0);
      chk("fill.no_res",   result_valid, 0);
      tick();
      chk("fill.fd_off",   fill_done_valid, 0);
      tick();
      lookup_expect("hit1", 32'h0000_1040, 4'd5, 1'b1, 2'd0);

      // Four back-to-back fills into set 1, then four pipelined lookups.
      do_reset();
      for (int i = 0; i <= 4; i++) begin
         idle();
         if (i < 4) begin
            fill_en   = 1'b1;
            fill_addr = fill_addrs[i];
         end
         if (i > 0) begin
            lru_fill_way_idx = fill_ways[i-1];
         end
         #1;
         if (i > 0) begin
            chk($sformatf("bb%0d.fd_valid", i-1), fill_done_valid, 1);
            chk($sformatf("bb%0d.fd_way", i-1),   fill_done_way_idx, fill_ways[i-1]);
            chk($sformatf("bb%0d.fd_set", i-1),   fill_done_set, 1);
         end
         tick();
      end
      idle();
      for (int i = 0; i <= 4; i++) begin
         lookup_en = 1'b0;
         if (i < 4) begin
            lookup_en   = 1'b1;
            lookup_addr = fill_addrs[i];
            lookup_id   = 4'(i);
         end
         #1;
         if (i > 0) begin
            chk($sformatf("bl%0d.hit", i-1), result_hit, 1);
            chk($sformatf("bl%0d.way", i-1), result_way_idx, fill_ways[i-1]);
            chk($sformatf("bl%0d.id", i-1),  result_id, i-1);
         end
         tick();
      end
      idle();

      // Lookup issued in the install cycle of the same line hits via forwarding.
      fill_en   = 1'b1;
      fill_addr = 32'h0000_2080;
      tick();
      idle();
      lru_fill_way_idx = 2'd1;
      lookup_en   = 1'b1;
      lookup_addr = 32'h0000_2080;
      lookup_id   = 4'd7;
      tick();
      idle();
      chk("fwd.hit", result_hit, 1);
      chk("fwd.way", result_way_idx, 1);
      chk("fwd.id",  result_id, 7);

      // Invalidate set 1 way 2; neighbours untouched.
      invalidate_en  = 1'b1;
      invalidate_set = 6'd1;
      invalidate_way = 2'd2;
      tick();
      idle();
      lookup_expect("inv.gone", 32'h0000_2040, 4'd1, 1'b0, 2'd0);
      lookup_expect("inv.keep", 32'h0000_3040, 4'd2, 1'b1, 2'd1);

      // Fill write and invalidate on the same edge to the same set/way: fill wins.
      fill_en   = 1'b1;
      fill_addr = 32'h0000_2040;
      tick();
      idle();
      lru_fill_way_idx = 2'd2;
      invalidate_en  = 1'b1;
      invalidate_set = 6'd1;
      invalidate_way = 2'd2;
      tick();
      idle();
      lookup_expect("coll", 32'h0000_2040, 4'd3, 1'b1, 2'd2);

      // Reset in the install cycle drops the fill and empties the cache.
      fill_en   = 1'b1;
      fill_addr = 32'h0000_3100;
      tick();
      idle();
      lru_fill_way_idx = 2'd0;
      rst_n = 1'b0;
      #1;
      chk("rstfill.fd_valid", fill_done_valid, 0);
      chk("rstfill.fd_way",   fill_done_way_idx, 0);
      tick();
      rst_n = 1'b1;
      tick();
      lookup_expect("rstfill.new", 32'h0000_3100, 4'd4, 1'b0, 2'd0);
      lookup_expect("rstfill.old", 32'h0000_1040, 4'd6, 1'b0, 2'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
